// File: rtl/sa_pkg.sv
// Shared types and constants for the 3x3 systolic matrix-multiply sequencer.
package sa_pkg;

    localparam int DW_DEF      = 8;
    localparam int RW_DEF      = 2 * DW_DEF + 1;
    localparam int RUN_LEN_DEF = 8;
    localparam int N_DIAG      = 5;

    localparam logic [N_DIAG-1:0] MASK_ALL = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // Position of C[i][j] in the flattened result vector.
    function automatic int flat_idx(input int i, input int j);
        return 3 * i + j;
    endfunction

    // Anti-diagonal (valid strobe number) that produces C[i][j].
    function automatic logic [2:0] diag_of(input int i, input int j);
        return 3'(i + j);
    endfunction

endpackage

// File: rtl/sa_skew_feeder.sv
// Operand register file for A and B plus the time-indexed skew mux that
// drives the array's x (row) and y (column) lanes.
module sa_skew_feeder
    import sa_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en_i,
    input  logic [1:0]      wr_idx_i,
    input  logic [3*DW-1:0] wr_a_row_i,
    input  logic [3*DW-1:0] wr_b_col_i,
    input  logic            feed_en_i,
    input  logic [TW-1:0]   feed_t_i,
    output logic [DW-1:0]   x1_o,
    output logic [DW-1:0]   x2_o,
    output logic [DW-1:0]   x3_o,
    output logic [DW-1:0]   y1_o,
    output logic [DW-1:0]   y2_o,
    output logic [DW-1:0]   y3_o
);

    logic [DW-1:0] a_q [3][3];
    logic [DW-1:0] b_q [3][3];
    logic [DW-1:0] x_d [3];
    logic [DW-1:0] y_d [3];
    logic [DW-1:0] x_q [3];
    logic [DW-1:0] y_q [3];

    // Beat k writes row k of A and column k of B.
    // NOTE: the operand file has no reset; all nine cells of both matrices
    // are rewritten by every job before the skew mux reads them.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int e = 0; e < 3; e++) begin
                a_q[wr_idx_i][e] <= wr_a_row_i[e*DW +: DW];
                b_q[e][wr_idx_i] <= wr_b_col_i[e*DW +: DW];
            end
        end
    end

    // Select the operand each lane carries in the upcoming run cycle.
    // NOTE: lanes default to zero first so no path through the mux leaves a
    // latch behind.
    always_comb begin
        for (int l = 0; l < 3; l++) begin
            x_d[l] = '0;
            y_d[l] = '0;
        end
        if (feed_en_i) begin
            for (int l = 0; l < 3; l++) begin
                for (int k = 0; k < 3; k++) begin
                    if (feed_t_i == TW'(l + k)) begin
                        x_d[l] = a_q[l][k];
                        y_d[l] = b_q[k][l];
                    end
                end
            end
        end
    end

    // Lane registers: the skewed operand is valid during the run cycle it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 3; l++) begin
                x_q[l] <= '0;
                y_q[l] <= '0;
            end
        end else begin
            for (int l = 0; l < 3; l++) begin
                x_q[l] <= x_d[l];
                y_q[l] <= y_d[l];
            end
        end
    end

    assign x1_o = x_q[0];
    assign x2_o = x_q[1];
    assign x3_o = x_q[2];
    assign y1_o = y_q[0];
    assign y2_o = y_q[1];
    assign y3_o = y_q[2];

endmodule

// File: rtl/sa_mm_sequencer.sv
// Job sequencer for the 3x3 signed systolic multiplier: loads A and B, runs
// the array with skewed operands, captures C per anti-diagonal strobe and
// hands the result matrix out over a valid/ready port. One job in flight.
module sa_mm_sequencer
    import sa_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int RUN_LEN = RUN_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3*DW-1:0]   in_a_row,
    input  logic [3*DW-1:0]   in_b_col,
    output logic              sa_start,
    output logic [DW-1:0]     sa_x1,
    output logic [DW-1:0]     sa_x2,
    output logic [DW-1:0]     sa_x3,
    output logic [DW-1:0]     sa_y1,
    output logic [DW-1:0]     sa_y2,
    output logic [DW-1:0]     sa_y3,
    input  logic              sa_v0,
    input  logic              sa_v1,
    input  logic              sa_v2,
    input  logic              sa_v3,
    input  logic              sa_v4,
    input  logic [2*DW:0]     sa_c11,
    input  logic [2*DW:0]     sa_c12,
    input  logic [2*DW:0]     sa_c13,
    input  logic [2*DW:0]     sa_c21,
    input  logic [2*DW:0]     sa_c22,
    input  logic [2*DW:0]     sa_c23,
    input  logic [2*DW:0]     sa_c31,
    input  logic [2*DW:0]     sa_c32,
    input  logic [2*DW:0]     sa_c33,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [9*(2*DW+1)-1:0] out_c,
    output logic              busy
);

    localparam int RW = 2 * DW + 1;
    localparam int TW = $clog2(RUN_LEN + 1);

    state_e            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [TW-1:0]     run_q, run_d;
    logic [N_DIAG-1:0] mask_q, mask_d;
    logic [9*RW-1:0]   out_c_q, out_c_d;
    logic              in_ready_q;

    logic [N_DIAG-1:0] strobe;
    logic [N_DIAG-1:0] capture;
    logic [RW-1:0]     c_in [9];
    logic              accept;

    assign strobe = {sa_v4, sa_v3, sa_v2, sa_v1, sa_v0};

    assign c_in[0] = sa_c11;
    assign c_in[1] = sa_c12;
    assign c_in[2] = sa_c13;
    assign c_in[3] = sa_c21;
    assign c_in[4] = sa_c22;
    assign c_in[5] = sa_c23;
    assign c_in[6] = sa_c31;
    assign c_in[7] = sa_c32;
    assign c_in[8] = sa_c33;

    assign accept = in_valid & in_ready_q;

    // Next-state logic: load three beats, run for RUN_LEN cycles, drain, then
    // either offer the result or drop the job if a diagonal never arrived.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        run_d   = run_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    beat_d  = 2'd1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (beat_q == 2'd2) begin
                        beat_d  = 2'd0;
                        run_d   = '0;
                        state_d = RUN;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            RUN: begin
                if (run_q == TW'(RUN_LEN - 1)) begin
                    run_d   = '0;
                    state_d = DRAIN;
                end else begin
                    run_d = run_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d = (mask_q == MASK_ALL) ? DONE : IDLE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result capture: first strobe per diagonal during RUN wins; the mask
    // restarts whenever the sequencer returns to IDLE.
    always_comb begin
        capture = (state_q == RUN) ? (strobe & ~mask_q) : '0;
        out_c_d = out_c_q;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (capture[diag_of(i, j)]) begin
                    out_c_d[flat_idx(i, j)*RW +: RW] = c_in[flat_idx(i, j)];
                end
            end
        end
        if (state_d == IDLE && state_q != IDLE) begin
            mask_d = '0;
        end else begin
            mask_d = mask_q | capture;
        end
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            run_q      <= '0;
            mask_q     <= '0;
            out_c_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            run_q      <= run_d;
            mask_q     <= mask_d;
            out_c_q    <= out_c_d;
            in_ready_q <= (state_d == IDLE) || (state_d == LOAD);
        end
    end

    sa_skew_feeder #(
        .DW (DW),
        .TW (TW)
    ) u_feeder (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (accept),
        .wr_idx_i   (beat_q),
        .wr_a_row_i (in_a_row),
        .wr_b_col_i (in_b_col),
        .feed_en_i  (state_d == RUN),
        .feed_t_i   (run_d),
        .x1_o       (sa_x1),
        .x2_o       (sa_x2),
        .x3_o       (sa_x3),
        .y1_o       (sa_y1),
        .y2_o       (sa_y2),
        .y3_o       (sa_y3)
    );

    assign in_ready  = in_ready_q;
    assign sa_start  = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_c     = out_c_q;

endmodule

// File: tb/tb_sa_mm_sequencer.sv
// Bench for sa_mm_sequencer: a behavioural systolic-array model answers the
// operand lanes with strobes and dot products; results are compared against
// a plain matrix product of the loaded operands.
module tb_sa_mm_sequencer;

    localparam int DW = 8;
    localparam int RW = 2 * DW + 1;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            out_ready = 1'b0;
    logic [3*DW-1:0] in_a_row  = '0;
    logic [3*DW-1:0] in_b_col  = '0;
    logic            in_ready, sa_start, out_valid, busy;
    logic [DW-1:0]   sa_x1, sa_x2, sa_x3, sa_y1, sa_y2, sa_y3;
    logic [9*RW-1:0] out_c;
    logic [4:0]      arr_v = '0;
    logic [RW-1:0]   arr_c [9] = '{default: '0};

    int vectors     = 0;
    int miscompares = 0;

    int  ma [3][3];
    int  mb [3][3];
    bit  suppress [5] = '{default: 1'b0};
    bit  spurious = 1'b0;
    bit  dbl      = 1'b0;
    logic signed [DW-1:0] hx [8][3];
    logic signed [DW-1:0] hy [8][3];
    int  run_cyc = 0;
    int  acc;

    always #5 clk = ~clk;

    sa_mm_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a_row  (in_a_row),
        .in_b_col  (in_b_col),
        .sa_start  (sa_start),
        .sa_x1     (sa_x1),
        .sa_x2     (sa_x2),
        .sa_x3     (sa_x3),
        .sa_y1     (sa_y1),
        .sa_y2     (sa_y2),
        .sa_y3     (sa_y3),
        .sa_v0     (arr_v[0]),
        .sa_v1     (arr_v[1]),
        .sa_v2     (arr_v[2]),
        .sa_v3     (arr_v[3]),
        .sa_v4     (arr_v[4]),
        .sa_c11    (arr_c[0]),
        .sa_c12    (arr_c[1]),
        .sa_c13    (arr_c[2]),
        .sa_c21    (arr_c[3]),
        .sa_c22    (arr_c[4]),
        .sa_c23    (arr_c[5]),
        .sa_c31    (arr_c[6]),
        .sa_c32    (arr_c[7]),
        .sa_c33    (arr_c[8]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .busy      (busy)
    );

    // Behavioural array: PE(i,j) multiplies lane x(i) delayed by j with lane
    // y(j) delayed by i; diagonal n is complete after run cycle n+2 and is
    // strobed in run cycle n+3.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_cyc = 0;
            arr_v   = '0;
        end else if (sa_start) begin
            if (run_cyc < 8) begin
                hx[run_cyc][0] = sa_x1; hx[run_cyc][1] = sa_x2; hx[run_cyc][2] = sa_x3;
                hy[run_cyc][0] = sa_y1; hy[run_cyc][1] = sa_y2; hy[run_cyc][2] = sa_y3;
            end
            arr_v = '0;
            for (int n = 0; n < 5; n++) begin
                if (run_cyc == n + 3 && !suppress[n]) begin
                    for (int i = 0; i < 3; i++) begin
                        for (int j = 0; j < 3; j++) begin
                            if (i + j == n) begin
                                acc = 0;
                                for (int tt = 0; tt <= run_cyc; tt++) begin
                                    if (tt - j >= 0 && tt - i >= 0)
                                        acc += int'(hx[tt-j][i]) * int'(hy[tt-i][j]);
                                end
                                arr_c[3*i+j] = acc[RW-1:0];
                            end
                        end
                    end
                    arr_v[n] = 1'b1;
                end
            end
            if (dbl && run_cyc == 7) begin
                arr_v[0] = 1'b1;
                arr_c[0] = 17'h15a5a;
            end
            run_cyc++;
        end else begin
            run_cyc = 0;
            arr_v   = spurious ? 5'h1f : 5'h00;
            if (spurious) begin
                for (int k = 0; k < 9; k++) arr_c[k] = 17'h0beef;
            end
        end
    end

    function automatic int rnd_op();
        logic [DW-1:0] r;
        r = DW'($urandom);
        return int'($signed(r));
    endfunction

    // Reference C = A x B, each element truncated to the RW-bit result field.
    function automatic logic [9*RW-1:0] ref_c();
        logic [9*RW-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++) s += ma[i][k] * mb[k][j];
                r[(3*i+j)*RW +: RW] = s[RW-1:0];
            end
        end
        return r;
    endfunction

    task automatic rand_mats();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = rnd_op();
                mb[i][j] = rnd_op();
            end
        end
    endtask

    // Offer the three load beats; returns at the negedge of run cycle t=0.
    task automatic load_job(output bit ok);
        int guard;
        ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            for (int e = 0; e < 3; e++) begin
                in_a_row[e*DW +: DW] = DW'(ma[k][e]);
                in_b_col[e*DW +: DW] = DW'(mb[e][k]);
            end
            guard = 0;
            while (!in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) ok = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Cycles from the last accepted beat until out_valid is seen (40 = timeout).
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, sa_start, out_valid, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000", {in_ready, sa_start, out_valid, busy});
        end
        vectors++;
        if ({sa_x1, sa_x2, sa_x3, sa_y1, sa_y2, sa_y3} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_lanes: got %h expected 0", {sa_x1, sa_x2, sa_x3, sa_y1, sa_y2, sa_y3});
        end
        vectors++;
        if (out_c !== '0) begin
            miscompares++;
            $display("FAIL reset_out_c: got %h expected 0", out_c);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ready: got in_ready=%b busy=%b expected 1 0", in_ready, busy);
        end
    endtask

    task automatic test_identity();
        bit ok;
        int lat;
        logic [9*RW-1:0] exp_id;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = (i == j) ? 1 : 0;
                mb[i][j] = 3 * i + j + 1;
            end
        end
        for (int k = 0; k < 9; k++) exp_id[k*RW +: RW] = RW'(k + 1);
        load_job(ok);
        vectors++;
        if (ok !== 1'b1) begin miscompares++; $display("FAIL identity_load: got timeout expected accept"); end
        wait_result(lat);
        vectors++;
        if (lat !== 10) begin miscompares++; $display("FAIL identity_latency: got %0d expected 10", lat); end
        vectors++;
        if (out_c !== exp_id) begin miscompares++; $display("FAIL identity_c: got %h expected %h", out_c, exp_id); end
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL done_flags: got busy=%b in_ready=%b expected 1 0", busy, in_ready);
        end
        handshake();
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_handshake: got v=%b busy=%b rdy=%b expected 0 0 1", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_extremes();
        bit ok;
        int lat;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = -128;
                mb[i][j] = -128;
            end
        end
        load_job(ok);
        wait_result(lat);
        vectors++;
        if (lat !== 10) begin miscompares++; $display("FAIL extremes_latency: got %0d expected 10", lat); end
        vectors++;
        if (out_c[RW-1:0] !== 17'd49152 || out_c[8*RW +: RW] !== 17'd49152) begin
            miscompares++;
            $display("FAIL extremes_corner: got %0d %0d expected 49152", out_c[RW-1:0], out_c[8*RW +: RW]);
        end
        vectors++;
        if (out_c !== ref_c()) begin miscompares++; $display("FAIL extremes_c: got %h expected %h", out_c, ref_c()); end
        handshake();
    endtask

    task automatic test_skew();
        bit ok;
        int lat, e, bad_t;
        logic [DW-1:0] got;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = 3 * i + j + 1;
                mb[i][j] = (i == j) ? 1 : 0;
            end
        end
        load_job(ok);
        wait_result(lat);
        for (int lane = 0; lane < 6; lane++) begin
            bad_t = -1;
            e = 0;
            got = '0;
            for (int t = 0; t < 8; t++) begin
                int l, k, ev;
                l = lane % 3;
                k = t - l;
                ev = 0;
                if (k >= 0 && k <= 2) ev = (lane < 3) ? ma[l][k] : mb[k][l];
                if (bad_t < 0 && ((lane < 3) ? hx[t][l] : hy[t][l]) !== DW'(ev)) begin
                    bad_t = t;
                    e = ev;
                    got = (lane < 3) ? hx[t][l] : hy[t][l];
                end
            end
            vectors++;
            if (bad_t >= 0) begin
                miscompares++;
                $display("FAIL skew_%s%0d: t=%0d got %0d expected %0d", (lane < 3) ? "x" : "y",
                         lane % 3 + 1, bad_t, $signed(got), e);
            end
        end
        vectors++;
        if (out_c !== ref_c()) begin miscompares++; $display("FAIL skew_c: got %h expected %h", out_c, ref_c()); end
        handshake();
    endtask

    task automatic test_stray_strobe();
        logic [9*RW-1:0] prev;
        prev = ref_c();
        spurious = 1'b1;
        repeat (2) @(negedge clk);
        spurious = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (out_c !== prev || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_strobe: got c=%h v=%b busy=%b expected c=%h 0 0", out_c, out_valid, busy, prev);
        end
    endtask

    task automatic test_drop();
        bit ok, seen;
        suppress[2] = 1'b1;
        rand_mats();
        load_job(ok);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= out_valid;
        end
        vectors++;
        if (seen !== 1'b0) begin miscompares++; $display("FAIL drop_no_valid: got out_valid=1 expected never"); end
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_idle: got busy=%b in_ready=%b expected 0 1", busy, in_ready);
        end
        suppress[2] = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok, stable;
        int lat;
        logic [9*RW-1:0] exp_c;
        rand_mats();
        load_job(ok);
        wait_result(lat);
        exp_c = ref_c();
        vectors++;
        if (lat !== 10) begin miscompares++; $display("FAIL bp_latency: got %0d expected 10", lat); end
        in_valid = 1'b1;
        in_a_row = 24'($urandom);
        in_b_col = 24'($urandom);
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (out_c !== exp_c || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) stable = 1'b0;
        end
        vectors++;
        if (stable !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold: got c=%h rdy=%b busy=%b v=%b expected c=%h 0 1 1", out_c, in_ready, busy, out_valid, exp_c);
        end
        in_valid = 1'b0;
        handshake();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_release: got busy=%b expected 0", busy); end
        rand_mats();
        load_job(ok);
        wait_result(lat);
        vectors++;
        if (out_c !== ref_c() || lat !== 10) begin
            miscompares++;
            $display("FAIL bp_second_job: got c=%h lat=%0d expected c=%h lat=10", out_c, lat, ref_c());
        end
        handshake();
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int lat;
        rand_mats();
        load_job(ok);
        repeat (4) @(negedge clk);
        vectors++;
        if (sa_start !== 1'b1) begin miscompares++; $display("FAIL midrun_running: got sa_start=%b expected 1", sa_start); end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({in_ready, sa_start, out_valid, busy, sa_x1, sa_x2, sa_x3, sa_y1, sa_y2, sa_y3} !== 52'h0 ||
            out_c !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset: got ctrl=%b c=%h expected all 0", {in_ready, sa_start, out_valid, busy}, out_c);
        end
        rst_n = 1'b1;
        @(negedge clk);
        rand_mats();
        load_job(ok);
        wait_result(lat);
        vectors++;
        if (out_c !== ref_c() || lat !== 10) begin
            miscompares++;
            $display("FAIL midrun_fresh_job: got c=%h lat=%0d expected c=%h lat=10", out_c, lat, ref_c());
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        for (int r = 0; r < 6; r++) begin
            dbl = r[0];
            rand_mats();
            load_job(ok);
            wait_result(lat);
            vectors++;
            if (lat !== 10) begin miscompares++; $display("FAIL b2b_latency[%0d]: got %0d expected 10", r, lat); end
            vectors++;
            if (out_c !== ref_c()) begin
                miscompares++;
                $display("FAIL b2b_c[%0d]: got %h expected %h", r, out_c, ref_c());
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake();
        end
        dbl = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_identity();
        test_extremes();
        test_skew();
        test_stray_strobe();
        test_drop();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
